// File: rtl/dds_spi_byte_tx.sv
// SPI byte transmitter for the DDS programming path: fetches N_BYTES bytes from the
// byte-stream reader and shifts them MSB-first (mode 0). Define DDS_IOUPDATE_EN to add the IO_UPDATE strobe.
module dds_spi_byte_tx #(
  parameter int N_BYTES   = 256,
  parameter int CLK_DIV   = 4,
  parameter int RD_LAT    = 2,
  parameter int IOUPD_LEN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] byte_in,
  output logic       byte_req,
  output logic [7:0] byte_idx,
  output logic       sclk,
  output logic       sdio,
  output logic       cs_n,
  output logic       io_update,
  output logic       busy,
  output logic       done
);

  localparam int MAX_A   = (RD_LAT > CLK_DIV) ? RD_LAT : CLK_DIV;
  localparam int MAX_CNT = (MAX_A > IOUPD_LEN) ? MAX_A : IOUPD_LEN;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] LOAD_LAST = CW'(RD_LAT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
  localparam logic [7:0]    LAST_IDX  = 8'(N_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
`ifdef DDS_IOUPDATE_EN
    IOUPD,
`endif
    FIN
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [2:0]      bit_cnt, bit_cnt_nxt;
  logic [6:0]      shreg, shreg_nxt;
  logic [7:0]      idx_nxt;
  logic            start_q, start_prev, start_edge;
  logic            byte_req_nxt, sclk_nxt, sdio_nxt, cs_n_nxt, busy_nxt, done_nxt;

  assign start_edge = start_q & ~start_prev;

  // All outputs are registered so cs_n, sclk and sdio are glitch-free at the pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      start_q    <= 1'b0;
      start_prev <= 1'b0;
      byte_req   <= 1'b0;
      byte_idx   <= '0;
      sclk       <= 1'b0;
      sdio       <= 1'b0;
      cs_n       <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shreg      <= shreg_nxt;
      start_q    <= start;
      start_prev <= start_q;
      byte_req   <= byte_req_nxt;
      byte_idx   <= idx_nxt;
      sclk       <= sclk_nxt;
      sdio       <= sdio_nxt;
      cs_n       <= cs_n_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

`ifdef DDS_IOUPDATE_EN
  localparam logic [CW-1:0] IOUPD_LAST = CW'(IOUPD_LEN - 1);
  logic io_update_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) io_update <= 1'b0;
    else     io_update <= io_update_nxt;
  end
`else
  assign io_update = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    bit_cnt_nxt  = bit_cnt;
    shreg_nxt    = shreg;
    idx_nxt      = byte_idx;
    sclk_nxt     = sclk;
    sdio_nxt     = sdio;
    cs_n_nxt     = cs_n;
    busy_nxt     = busy;
    byte_req_nxt = 1'b0;
    done_nxt     = 1'b0;
`ifdef DDS_IOUPDATE_EN
    io_update_nxt = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start_edge) begin
          state_nxt    = LOAD;
          cnt_nxt      = '0;
          idx_nxt      = '0;
          cs_n_nxt     = 1'b0;
          busy_nxt     = 1'b1;
          byte_req_nxt = 1'b1;
        end
      end
      // The byte arrives RD_LAT cycles after the request, i.e. in the last LOAD cycle.
      LOAD: begin
        if (cnt == LOAD_LAST) begin
          cnt_nxt     = '0;
          bit_cnt_nxt = '0;
          shreg_nxt   = byte_in[6:0];
          sdio_nxt    = byte_in[7];
          state_nxt   = SHIFT;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      SHIFT: begin
        if (cnt != HALF_LAST) begin
          cnt_nxt = cnt + 1'b1;
        end else begin
          cnt_nxt = '0;
          if (!sclk) begin
            sclk_nxt = 1'b1;
          end else begin
            sclk_nxt = 1'b0;
            if (bit_cnt != 3'd7) begin
              bit_cnt_nxt = bit_cnt + 1'b1;
              sdio_nxt    = shreg[6];
              shreg_nxt   = {shreg[5:0], 1'b0};
            end else if (byte_idx != LAST_IDX) begin
              idx_nxt      = byte_idx + 1'b1;
              byte_req_nxt = 1'b1;
              state_nxt    = LOAD;
            end else begin
              cs_n_nxt = 1'b1;
              sdio_nxt = 1'b0;
`ifdef DDS_IOUPDATE_EN
              state_nxt = IOUPD;
`else
              state_nxt = FIN;
`endif
            end
          end
        end
      end
`ifdef DDS_IOUPDATE_EN
      IOUPD: begin
        io_update_nxt = 1'b1;
        if (cnt == IOUPD_LAST) begin
          cnt_nxt   = '0;
          state_nxt = FIN;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
`endif
      FIN: begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
